// File: rtl/alu_seq.sv
// alu_seq: registered arith/logic ALU with iterative unsigned multiply/divide.
// Single-cycle ops complete on the accept edge. MULU and DIVU run one bit per
// cycle behind a start/busy/done handshake so the control unit can stall.
// All outputs are registered and hold their values until the next done pulse.
module alu_seq #(
    parameter int WIDTH     = 32,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       AluOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Result_hi,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MULU = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1101;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIN
    } state_t;

    state_t state;

    // Iteration registers shared by multiply and divide.
    // MUL: work_hi = partial product high, work_lo = multiplier shifting out.
    // DIV: work_hi = partial remainder,    work_lo = dividend shifting out / quotient in.
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] work_lo;
    logic [WIDTH-1:0] operand;
    logic [SHW-1:0]   iter_cnt;
    logic             div_zero;

    logic [WIDTH-1:0] mul_hi_next;
    logic [WIDTH-1:0] mul_lo_next;
    logic [WIDTH-1:0] div_hi_next;
    logic [WIDTH-1:0] div_lo_next;

    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sc_result;
    logic             sc_carry;
    logic             sc_overflow;
    logic             sc_err;
    logic             is_mul;
    logic             is_div;
    logic             can_accept;

    assign add_ext    = {1'b0, A} + {1'b0, B};
    assign sub_ext    = {1'b0, A} + {1'b0, ~B} + (WIDTH + 1)'(1);
    assign shamt      = B[SHW-1:0];
    assign is_mul     = MULDIV_EN && (AluOp == OP_MULU);
    assign is_div     = MULDIV_EN && (AluOp == OP_DIVU);
    assign can_accept = (state == IDLE) || (state == FIN);

    // Single-cycle datapath: result, carry, overflow and reserved-op detection.
    always_comb begin
        sc_result   = '0;
        sc_carry    = 1'b0;
        sc_overflow = 1'b0;
        sc_err      = 1'b0;
        case (AluOp)
            OP_ADD: begin
                sc_result   = add_ext[WIDTH-1:0];
                sc_carry    = add_ext[WIDTH];
                sc_overflow = (A[WIDTH-1] == B[WIDTH-1]) &&
                              (add_ext[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_result   = sub_ext[WIDTH-1:0];
                sc_carry    = sub_ext[WIDTH];
                sc_overflow = (A[WIDTH-1] != B[WIDTH-1]) &&
                              (sub_ext[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_AND:  sc_result = A & B;
            OP_OR:   sc_result = A | B;
            OP_XOR:  sc_result = A ^ B;
            OP_NOR:  sc_result = ~(A | B);
            OP_SLL:  sc_result = A << shamt;
            OP_SRL:  sc_result = A >> shamt;
            OP_SRA:  sc_result = $unsigned($signed(A) >>> shamt);
            default: sc_err    = 1'b1;
        endcase
    end

    generate
        if (MULDIV_EN) begin : g_muldiv
            logic [WIDTH:0] mul_sum;
            logic [WIDTH:0] div_shift;
            logic [WIDTH:0] div_diff;

            // One shift-add multiply step: conditionally add multiplicand, shift right.
            always_comb begin
                mul_sum     = {1'b0, work_hi} + (work_lo[0] ? {1'b0, operand} : '0);
                mul_hi_next = mul_sum[WIDTH:1];
                mul_lo_next = {mul_sum[0], work_lo[WIDTH-1:1]};
            end

            // One restoring divide step: trial-subtract divisor, keep it only when no borrow.
            always_comb begin
                div_shift = {work_hi, work_lo[WIDTH-1]};
                div_diff  = div_shift - {1'b0, operand};
                if (!div_diff[WIDTH]) begin
                    div_hi_next = div_diff[WIDTH-1:0];
                    div_lo_next = {work_lo[WIDTH-2:0], 1'b1};
                end else begin
                    div_hi_next = div_shift[WIDTH-1:0];
                    div_lo_next = {work_lo[WIDTH-2:0], 1'b0};
                end
            end
        end else begin : g_no_muldiv
            assign mul_hi_next = '0;
            assign mul_lo_next = '0;
            assign div_hi_next = '0;
            assign div_lo_next = '0;
        end
    endgenerate

    // Control FSM plus registered outputs; done/err default low so they pulse for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            work_hi   <= '0;
            work_lo   <= '0;
            operand   <= '0;
            iter_cnt  <= '0;
            div_zero  <= 1'b0;
            Result    <= '0;
            Result_hi <= '0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (start && can_accept) begin
                        if (is_mul) begin
                            work_hi  <= '0;
                            work_lo  <= B;
                            operand  <= A;
                            iter_cnt <= '0;
                            busy     <= 1'b1;
                            state    <= MUL;
                        end else if (is_div) begin
                            work_hi  <= '0;
                            work_lo  <= A;
                            operand  <= B;
                            iter_cnt <= '0;
                            div_zero <= (B == '0);
                            busy     <= 1'b1;
                            state    <= DIV;
                        end else begin
                            Result    <= sc_result;
                            Result_hi <= '0;
                            zero      <= (sc_result == '0);
                            negative  <= sc_result[WIDTH-1];
                            carry     <= sc_carry;
                            overflow  <= sc_overflow;
                            err       <= sc_err;
                            done      <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    work_hi  <= mul_hi_next;
                    work_lo  <= mul_lo_next;
                    iter_cnt <= iter_cnt + 1'b1;
                    if (iter_cnt == LAST_ITER) begin
                        Result    <= mul_lo_next;
                        Result_hi <= mul_hi_next;
                        zero      <= (mul_lo_next == '0);
                        negative  <= mul_lo_next[WIDTH-1];
                        carry     <= 1'b0;
                        overflow  <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= FIN;
                    end
                end
                DIV: begin
                    if (div_zero) begin
                        Result    <= '1;
                        Result_hi <= work_lo;
                        zero      <= 1'b0;
                        negative  <= 1'b1;
                        carry     <= 1'b0;
                        overflow  <= 1'b0;
                        err       <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= FIN;
                    end else begin
                        work_hi  <= div_hi_next;
                        work_lo  <= div_lo_next;
                        iter_cnt <= iter_cnt + 1'b1;
                        if (iter_cnt == LAST_ITER) begin
                            Result    <= div_lo_next;
                            Result_hi <= div_hi_next;
                            zero      <= (div_lo_next == '0);
                            negative  <= div_lo_next[WIDTH-1];
                            carry     <= 1'b0;
                            overflow  <= 1'b0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state     <= FIN;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: reference model feeds a scoreboard queue,
// each scenario task pops and compares when the DUT raises done.
module tb_alu_seq;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         z;
        logic         n;
        logic         c;
        logic         v;
        logic         e;
    } out_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         start_nomd;
    logic [3:0]   alu_op;
    logic [W-1:0] a;
    logic [W-1:0] b;

    logic [W-1:0] res, res_hi;
    logic         zero, negative, carry, overflow, busy, done, err;
    logic [W-1:0] res_nm, res_hi_nm;
    logic         zero_nm, negative_nm, carry_nm, overflow_nm, busy_nm, done_nm, err_nm;

    out_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [3:0]   sc_op [14] = '{4'h0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h4, 4'h5,
                                 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'h2, 4'h3};
    logic [W-1:0] sc_a  [14] = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'd3, 32'h80000000,
                                 32'hF0F0A5A5, 32'h0F0F0000, 32'hFFFF0000, 32'h12345678,
                                 32'h00000001, 32'h80000000, 32'h80000000, 32'hFFFFFFFF,
                                 32'hFFFFFFFF};
    logic [W-1:0] sc_b  [14] = '{32'd1, 32'd5, 32'd1, 32'd5, 32'd1,
                                 32'h0FF0FF00, 32'h000000F0, 32'h0F0F0F0F, 32'h0000000F,
                                 32'h00000021, 32'h0000001F, 32'h00000024, 32'd1,
                                 32'd1};

    alu_seq #(.WIDTH(W), .MULDIV_EN(1'b1)) u_dut (
        .clk(clk), .reset(reset), .start(start), .AluOp(alu_op), .A(a), .B(b),
        .Result(res), .Result_hi(res_hi), .zero(zero), .negative(negative),
        .carry(carry), .overflow(overflow), .busy(busy), .done(done), .err(err)
    );

    alu_seq #(.WIDTH(W), .MULDIV_EN(1'b0)) u_dut_nomd (
        .clk(clk), .reset(reset), .start(start_nomd), .AluOp(alu_op), .A(a), .B(b),
        .Result(res_nm), .Result_hi(res_hi_nm), .zero(zero_nm), .negative(negative_nm),
        .carry(carry_nm), .overflow(overflow_nm), .busy(busy_nm), .done(done_nm), .err(err_nm)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Watchdog so the bench never hangs.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic out_t model(input logic [3:0] op, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input logic md_en);
        out_t          o;
        logic [W:0]    s;
        logic [2*W-1:0] p;
        o = '0;
        case (op)
            4'h0: begin
                s    = {1'b0, x} + {1'b0, y};
                o.res = s[W-1:0];
                o.c  = s[W];
                o.v  = (x[W-1] == y[W-1]) && (o.res[W-1] != x[W-1]);
            end
            4'h1: begin
                o.res = x - y;
                o.c  = (x >= y);
                o.v  = (x[W-1] != y[W-1]) && (o.res[W-1] != x[W-1]);
            end
            4'h2: o.res = ($signed(x) < $signed(y)) ? 1 : 0;
            4'h3: o.res = (x < y) ? 1 : 0;
            4'h4: o.res = x & y;
            4'h5: o.res = x | y;
            4'h6: o.res = x ^ y;
            4'h7: o.res = ~(x | y);
            4'h8: o.res = x << y[4:0];
            4'h9: o.res = x >> y[4:0];
            4'hA: o.res = $unsigned($signed(x) >>> y[4:0]);
            4'hC: begin
                if (md_en) begin
                    p     = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                    o.res = p[W-1:0];
                    o.hi  = p[2*W-1:W];
                end else begin
                    o.e = 1'b1;
                end
            end
            4'hD: begin
                if (!md_en) begin
                    o.e = 1'b1;
                end else if (y == 0) begin
                    o.res = '1;
                    o.hi  = x;
                    o.e   = 1'b1;
                end else begin
                    o.res = x / y;
                    o.hi  = x % y;
                end
            end
            default: o.e = 1'b1;
        endcase
        o.z = (o.res == 0);
        o.n = o.res[W-1];
        return o;
    endfunction

    function automatic out_t obs_main();
        return {res, res_hi, zero, negative, carry, overflow, err};
    endfunction

    function automatic out_t obs_nomd();
        return {res_nm, res_hi_nm, zero_nm, negative_nm, carry_nm, overflow_nm, err_nm};
    endfunction

    // Pulse start for one accept edge, push the model result, then scramble operands.
    task automatic drive_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        alu_op = op;
        a      = x;
        b      = y;
        start  = 1'b1;
        exp_q.push_back(model(op, x, y, 1'b1));
        @(negedge clk);
        start = 1'b0;
        a     = ~x;
        b     = ~y;
    endtask

    // Count cycles after accept until done (n = -1 on timeout) and busy cycles seen.
    task automatic wait_done(output int n, output int nb);
        n  = 1;
        nb = 0;
        while (!done) begin
            if (busy) nb++;
            if (n >= 200) begin
                n = -1;
                return;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        start      = 1'b0;
        start_nomd = 1'b0;
        alu_op     = 4'h0;
        a          = '1;
        b          = '1;
        repeat (3) @(negedge clk);
        checks++;
        if ({obs_main(), busy, done} !== '0 || {obs_nomd(), busy_nm, done_nm} !== '0) begin
            $display("[TB] FAIL reset_state: got main=%h busy=%b done=%b nomd=%h, want all zero",
                     obs_main(), busy, done, obs_nomd());
            errors++;
        end
        reset = 1'b0;
    endtask

    task automatic test_single_cycle();
        int   n, nb;
        out_t e;
        for (int i = 0; i < 14; i++) begin
            drive_op(sc_op[i], sc_a[i], sc_b[i]);
            wait_done(n, nb);
            e = exp_q.pop_front();
            checks++;
            if (n !== 1 || nb !== 0 || obs_main() !== e) begin
                $display("[TB] FAIL single_op[%0d] op=%h: got lat=%0d busy=%0d out=%h, want lat=1 busy=0 out=%h",
                         i, sc_op[i], n, nb, obs_main(), e);
                errors++;
            end
        end
        repeat (3) @(negedge clk);
        e.e = 1'b0;
        checks++;
        if (done !== 1'b0 || obs_main() !== e) begin
            $display("[TB] FAIL output_hold: got done=%b out=%h, want done=0 out=%h", done, obs_main(), e);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]   op [3] = '{4'h0, 4'h6, 4'h1};
        logic [W-1:0] x  [3] = '{32'd1, 32'hAAAA5555, 32'd3};
        logic [W-1:0] y  [3] = '{32'd2, 32'h0000FFFF, 32'd10};
        out_t e;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (done !== 1'b1 || obs_main() !== e) begin
                    $display("[TB] FAIL back_to_back[%0d]: got done=%b out=%h, want done=1 out=%h",
                             i - 1, done, obs_main(), e);
                    errors++;
                end
            end
            if (i < 3) begin
                alu_op = op[i];
                a      = x[i];
                b      = y[i];
                start  = 1'b1;
                exp_q.push_back(model(op[i], x[i], y[i], 1'b1));
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            $display("[TB] FAIL back_to_back_end: got done=%b, want 0", done);
            errors++;
        end
    endtask

    task automatic test_mulu();
        int   nb = 0, dn = -1, dcount = 0;
        out_t e, got;
        got = '0;
        drive_op(4'hC, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int n = 1; n <= 45; n++) begin
            if (busy) nb++;
            if (done) begin
                dcount++;
                if (dn < 0) begin
                    dn  = n;
                    got = obs_main();
                end
            end
            if (n == 4) begin
                alu_op = 4'h0;
                a      = 32'd7;
                b      = 32'd9;
                start  = 1'b1;
            end else if (n == 5) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        e = exp_q.pop_front();
        checks++;
        if (nb !== 32 || dn !== 33 || dcount !== 1) begin
            $display("[TB] FAIL mulu_timing: got busy=%0d done_at=%0d dones=%0d, want busy=32 done_at=33 dones=1",
                     nb, dn, dcount);
            errors++;
        end
        checks++;
        if (got !== e) begin
            $display("[TB] FAIL mulu_result: got %h, want %h", got, e);
            errors++;
        end
        drive_op(4'hC, 32'h0001_2345, 32'h0000_ABCD);
        wait_done(dn, nb);
        e = exp_q.pop_front();
        checks++;
        if (dn !== 33 || obs_main() !== e) begin
            $display("[TB] FAIL mulu_small: got lat=%0d out=%h, want lat=33 out=%h", dn, obs_main(), e);
            errors++;
        end
    endtask

    task automatic test_divu();
        int   n, nb;
        out_t e;
        @(negedge clk);
        drive_op(4'hD, 32'd100, 32'd7);
        wait_done(n, nb);
        e = exp_q.pop_front();
        checks++;
        if (n !== 33 || nb !== 32 || obs_main() !== e) begin
            $display("[TB] FAIL divu_100_7: got lat=%0d busy=%0d out=%h, want lat=33 busy=32 out=%h",
                     n, nb, obs_main(), e);
            errors++;
        end
        @(negedge clk);
        drive_op(4'hD, 32'hDEADBEEF, 32'h00001234);
        wait_done(n, nb);
        e = exp_q.pop_front();
        checks++;
        if (n !== 33 || obs_main() !== e) begin
            $display("[TB] FAIL divu_big: got lat=%0d out=%h, want lat=33 out=%h", n, obs_main(), e);
            errors++;
        end
        @(negedge clk);
        drive_op(4'hD, 32'd9, 32'd0);
        wait_done(n, nb);
        e = exp_q.pop_front();
        checks++;
        if (n !== 2 || nb !== 1 || obs_main() !== e) begin
            $display("[TB] FAIL divu_by_zero: got lat=%0d busy=%0d out=%h, want lat=2 busy=1 out=%h",
                     n, nb, obs_main(), e);
            errors++;
        end
    endtask

    task automatic test_reset_midop();
        int   n, nb, dcount = 0;
        out_t e;
        @(negedge clk);
        alu_op = 4'hC;
        a      = 32'h00001234;
        b      = 32'h00005678;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 10; k++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({obs_main(), busy, done} !== '0) begin
            $display("[TB] FAIL reset_midop: got out=%h busy=%b done=%b, want all zero", obs_main(), busy, done);
            errors++;
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        checks++;
        if (dcount !== 0) begin
            $display("[TB] FAIL reset_no_done: got %0d done pulses, want 0", dcount);
            errors++;
        end
        drive_op(4'h0, 32'd2, 32'd3);
        wait_done(n, nb);
        e = exp_q.pop_front();
        checks++;
        if (n !== 1 || obs_main() !== e) begin
            $display("[TB] FAIL add_after_reset: got lat=%0d out=%h, want lat=1 out=%h", n, obs_main(), e);
            errors++;
        end
    endtask

    task automatic test_reserved();
        logic [3:0] rop [3] = '{4'hE, 4'hB, 4'hF};
        int         n, nb;
        out_t       e;
        for (int i = 0; i < 3; i++) begin
            drive_op(rop[i], 32'h12345678, 32'h9ABCDEF0);
            wait_done(n, nb);
            e = exp_q.pop_front();
            checks++;
            if (n !== 1 || nb !== 0 || obs_main() !== e) begin
                $display("[TB] FAIL reserved_op %h: got lat=%0d busy=%0d out=%h, want lat=1 busy=0 out=%h",
                         rop[i], n, nb, obs_main(), e);
                errors++;
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            alu_op     = (i == 0) ? 4'hC : 4'hD;
            a          = 32'h0000FFFF;
            b          = 32'h00000003;
            start_nomd = 1'b1;
            exp_q.push_back(model(alu_op, a, b, 1'b0));
            @(negedge clk);
            start_nomd = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (done_nm !== 1'b1 || busy_nm !== 1'b0 || obs_nomd() !== e) begin
                $display("[TB] FAIL nomd_op[%0d]: got done=%b busy=%b out=%h, want done=1 busy=0 out=%h",
                         i, done_nm, busy_nm, obs_nomd(), e);
                errors++;
            end
        end
    endtask

    initial begin
        $display("[TB] alu_seq bench starting");
        test_reset();
        test_single_cycle();
        test_back_to_back();
        test_mulu();
        test_divu();
        test_reset_midop();
        test_reserved();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
